// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: a chain of 1-bit full-adder cells feeding one output register.
// Optional signed-overflow output enabled by defining FA_OVERFLOW_EN.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module full_adder_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_vld,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_vld
`ifdef FA_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             vld_d, vld_q;

  assign carry[0] = Cin;

  // One cell per bit; carry[i+1] ripples out of cell i.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  always_comb begin
    s_d    = s_q;
    cout_d = cout_q;
    vld_d  = in_vld;
    if (in_vld) begin
      s_d    = sum;
      cout_d = carry[WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign S       = s_q;
  assign Cout    = cout_q;
  assign out_vld = vld_q;

`ifdef FA_OVERFLOW_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (in_vld) begin
      ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// Self-checking bench for full_adder_reg: WIDTH=1, 8 and 16 instances sharing clk/rst,
// directed corner cases plus a randomized WIDTH=16 run against an arithmetic model.

module tb_full_adder_reg;

  logic clk;
  logic rst;

  logic        a1, b1, cin1, vld1, s1, cout1, ovld1;
  logic [7:0]  a8, b8, s8;
  logic        cin8, vld8, cout8, ovld8;
  logic [15:0] a16, b16, s16;
  logic        cin16, vld16, cout16, ovld16;
`ifdef FA_OVERFLOW_EN
  logic        ovf1, ovf8, ovf16;
`endif

  int totalChecks;
  int badChecks;

  full_adder_reg #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .in_vld(vld1),
    .S(s1), .Cout(cout1), .out_vld(ovld1)
`ifdef FA_OVERFLOW_EN
    , .Ovf(ovf1)
`endif
  );

  full_adder_reg #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin8), .in_vld(vld8),
    .S(s8), .Cout(cout8), .out_vld(ovld8)
`ifdef FA_OVERFLOW_EN
    , .Ovf(ovf8)
`endif
  );

  full_adder_reg #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(cin16), .in_vld(vld16),
    .S(s16), .Cout(cout16), .out_vld(ovld16)
`ifdef FA_OVERFLOW_EN
    , .Ovf(ovf16)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Drive one lane at the falling edge, idle the others, then wait past the capturing edge.
  task automatic applyStimulus(input int lane, input logic [63:0] a, input logic [63:0] b,
                               input logic cin, input logic vld);
    @(negedge clk);
    vld1 = 1'b0; vld8 = 1'b0; vld16 = 1'b0;
    case (lane)
      1:  begin a1  = a[0];     b1  = b[0];     cin1  = cin; vld1  = vld; end
      8:  begin a8  = a[7:0];   b8  = b[7:0];   cin8  = cin; vld8  = vld; end
      default: begin a16 = a[15:0]; b16 = b[15:0]; cin16 = cin; vld16 = vld; end
    endcase
    @(posedge clk);
    #1;
  endtask

`ifdef FA_OVERFLOW_EN
  // Signed overflow: true signed result falls outside the w-bit two's-complement range.
  function automatic logic refOvf(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin);
    longint sa, sb, res, maxv, minv;
    sa = longint'(a);
    sb = longint'(b);
    if (a[w-1]) sa = sa - (longint'(1) <<< w);
    if (b[w-1]) sb = sb - (longint'(1) <<< w);
    res  = sa + sb + longint'(cin);
    maxv = (longint'(1) <<< (w - 1)) - 1;
    minv = -(longint'(1) <<< (w - 1));
    return (res > maxv) || (res < minv);
  endfunction
`endif

  initial begin
    logic [63:0] sum;
    logic [15:0] ra, rb;
    logic        rc, rv;
    logic [15:0] expS16;
    logic        expC16, expV16;
`ifdef FA_OVERFLOW_EN
    logic        expO16;
`endif

    totalChecks = 0;
    badChecks   = 0;
    rst = 1'b1;
    a1 = 0; b1 = 0; cin1 = 0; vld1 = 0;
    a8 = 0; b8 = 0; cin8 = 0; vld8 = 0;
    a16 = 0; b16 = 0; cin16 = 0; vld16 = 0;

    #2;
    checkOutput("rst_s1",     64'(s1),     64'd0);
    checkOutput("rst_cout1",  64'(cout1),  64'd0);
    checkOutput("rst_vld1",   64'(ovld1),  64'd0);
    checkOutput("rst_s8",     64'(s8),     64'd0);
    checkOutput("rst_vld16",  64'(ovld16), 64'd0);
`ifdef FA_OVERFLOW_EN
    checkOutput("rst_ovf8",   64'(ovf8),   64'd0);
`endif

    @(negedge clk);
    rst = 1'b0;

    // Exhaustive WIDTH=1 full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      applyStimulus(1, 64'(v[2]), 64'(v[1]), v[0], 1'b1);
      sum = 64'(v[2]) + 64'(v[1]) + 64'(v[0]);
      checkOutput($sformatf("fa1_s_%0d", i),    64'(s1),    64'(sum[0]));
      checkOutput($sformatf("fa1_cout_%0d", i), 64'(cout1), 64'(sum[1]));
      checkOutput($sformatf("fa1_vld_%0d", i),  64'(ovld1), 64'd1);
`ifdef FA_OVERFLOW_EN
      checkOutput($sformatf("fa1_ovf_%0d", i),  64'(ovf1),
                  64'(refOvf(1, 64'(v[2]), 64'(v[1]), v[0])));
`endif
    end

    // Hold: load 1+1+0, then drop valid with changed (and unknown) inputs.
    applyStimulus(1, 64'd1, 64'd1, 1'b0, 1'b1);
    checkOutput("hold_load_s",    64'(s1),    64'd0);
    checkOutput("hold_load_cout", 64'(cout1), 64'd1);
    applyStimulus(1, 64'd0, 64'd0, 1'b0, 1'b0);
    checkOutput("hold_s",    64'(s1),    64'd0);
    checkOutput("hold_cout", 64'(cout1), 64'd1);
    checkOutput("hold_vld",  64'(ovld1), 64'd0);
    applyStimulus(1, 'x, 'x, 1'bx, 1'b0);
    checkOutput("holdx_s",    64'(s1),    64'd0);
    checkOutput("holdx_cout", 64'(cout1), 64'd1);

    // WIDTH=8 wrap-around corners.
    applyStimulus(8, 64'hFF, 64'h00, 1'b1, 1'b1);
    checkOutput("wrap0_s",    64'(s8),    64'h00);
    checkOutput("wrap0_cout", 64'(cout8), 64'd1);
    checkOutput("wrap0_vld",  64'(ovld8), 64'd1);
    applyStimulus(8, 64'hFF, 64'hFF, 1'b1, 1'b1);
    checkOutput("wrap1_s",    64'(s8),    64'hFF);
    checkOutput("wrap1_cout", 64'(cout8), 64'd1);

`ifdef FA_OVERFLOW_EN
    applyStimulus(8, 64'h7F, 64'h01, 1'b0, 1'b1);
    checkOutput("ovfA_s",    64'(s8),    64'h80);
    checkOutput("ovfA_ovf",  64'(ovf8),  64'd1);
    checkOutput("ovfA_cout", 64'(cout8), 64'd0);
    applyStimulus(8, 64'h80, 64'h80, 1'b0, 1'b1);
    checkOutput("ovfB_s",    64'(s8),    64'h00);
    checkOutput("ovfB_ovf",  64'(ovf8),  64'd1);
    checkOutput("ovfB_cout", 64'(cout8), 64'd1);
    applyStimulus(8, 64'h01, 64'hFF, 1'b0, 1'b1);
    checkOutput("ovfC_ovf",  64'(ovf8),  64'd0);
    applyStimulus(8, 64'hFF, 64'hFF, 1'b1, 1'b1);
`endif

    // Asynchronous reset between edges while S8 is nonzero.
    @(negedge clk);
    vld1 = 1'b0; vld8 = 1'b0; vld16 = 1'b0;
    #1;
    checkOutput("pre_rst_s8", 64'(s8), 64'hFF);
    rst = 1'b1;
    #1;
    checkOutput("arst_s8",    64'(s8),    64'h00);
    checkOutput("arst_cout8", 64'(cout8), 64'd0);
    checkOutput("arst_vld8",  64'(ovld8), 64'd0);
    checkOutput("arst_cout1", 64'(cout1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8, 64'd3, 64'd4, 1'b0, 1'b1);
    checkOutput("post_rst_s",    64'(s8),    64'd7);
    checkOutput("post_rst_cout", 64'(cout8), 64'd0);
    checkOutput("post_rst_vld",  64'(ovld8), 64'd1);

    // Randomized WIDTH=16 run against A+B+Cin, held on invalid cycles.
    expS16 = '0;
    expC16 = 1'b0;
    expV16 = 1'b0;
`ifdef FA_OVERFLOW_EN
    expO16 = 1'b0;
`endif
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rv = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        ra = 16'hFFFF;
        rb = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'hFFFF;
      end
      applyStimulus(16, 64'(ra), 64'(rb), rc, rv);
      if (rv) begin
        sum = 64'(ra) + 64'(rb) + 64'(rc);
        expS16 = sum[15:0];
        expC16 = sum[16];
`ifdef FA_OVERFLOW_EN
        expO16 = refOvf(16, 64'(ra), 64'(rb), rc);
`endif
      end
      expV16 = rv;
      checkOutput("rnd_s",    64'(s16),    64'(expS16));
      checkOutput("rnd_cout", 64'(cout16), 64'(expC16));
      checkOutput("rnd_vld",  64'(ovld16), 64'(expV16));
`ifdef FA_OVERFLOW_EN
      checkOutput("rnd_ovf",  64'(ovf16),  64'(expO16));
`endif
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
